// File: rtl/apb_master_bridge.sv
// Command-stream to APB4 master bridge: one outstanding transfer, wait-state
// timeout, and a held response until the consumer accepts it.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // NOTE: cmd_ready is a pure decode of the state register, so it stays
  // glitch-free and carries no combinational path from any input.
  assign cmd_ready = (state == IDLE);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= SETUP;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            // Reads drive zero data and strobes, as APB4 requires.
            PWDATA  <= cmd_write ? cmd_wdata : '0;
            PSTRB   <= cmd_write ? cmd_strb : '0;
          end
        end

        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end

        ACCESS: begin
          if (PREADY) begin
            state       <= RESP;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Abort after the last allowed ACCESS cycle still saw no PREADY.
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
              state       <= RESP;
              PSELx       <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
